// File: rtl/wdt_reset_sequencer.sv
// Watchdog time base plus bite-to-board-reset sequencer with retry counting and sticky recovery.
// Optional build macro WDT_SEQ_BITE_COUNT_EN adds a saturating accepted-bite total at BASE+3.
module wdt_reset_sequencer #(
  parameter logic [4:0]  BASE_ADDR     = 5'h8,
  parameter logic [15:0] PRESCALE      = 16'd31,
  parameter logic [7:0]  ASSERT_TICKS  = 8'd4,
  parameter logic [7:0]  HOLDOFF_TICKS = 8'd8,
  parameter logic [2:0]  MAX_RETRIES   = 3'd3,
  parameter logic [7:0]  BOOTOK_VALUE  = 8'ha5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  output logic       wdt_ce,
  input  logic [1:0] bite_strobe,
  input  logic       recovery_req,
  output logic       reset_out,
  output logic       recovery_out,
  output logic       irq
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ASSERT = 2'd1, S_HOLDOFF = 2'd2} state_e;

  localparam logic [7:0] ASSERT_N = (ASSERT_TICKS == 8'd0) ? 8'd1 : ASSERT_TICKS;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  tick_q, tick_d;
  logic [2:0]  retry_q, retry_d, retry_base;
  logic [1:0]  cause_q, cause_d;
  logic        reset_out_q, reset_out_d;
  logic        rec_q, rec_d;
  logic        irq_q, irq_d;
  logic [4:0]  off;
  logic        hit, wr_bootok, wr_clear, bite_acc, rec_set;
  logic [7:0]  reg3_val;

  assign off       = csr_a - BASE_ADDR;
  assign hit       = (off[4:2] == 3'd0);
  assign wr_bootok = csr_we && hit && (off[1:0] == 2'd1) && (csr_di == BOOTOK_VALUE);
  assign wr_clear  = csr_we && hit && (off[1:0] == 2'd2) && csr_di[0];
  assign bite_acc  = (state_q == S_IDLE) && (|bite_strobe);
  assign wdt_ce    = (presc_q == 16'd0);

  always_comb begin
    presc_d     = (presc_q == 16'd0) ? PRESCALE : presc_q - 16'd1;
    state_d     = state_q;
    tick_d      = tick_q;
    reset_out_d = reset_out_q;
    case (state_q)
      S_IDLE: if (bite_acc) begin
        state_d     = S_ASSERT;
        reset_out_d = 1'b1;
        tick_d      = 8'd0;
      end
      S_ASSERT: if (tick_q >= ASSERT_N) begin
        // A zero holdoff skips the blanking state entirely
        state_d     = (HOLDOFF_TICKS == 8'd0) ? S_IDLE : S_HOLDOFF;
        reset_out_d = 1'b0;
        tick_d      = 8'd0;
      end else if (wdt_ce) begin
        tick_d = tick_q + 8'd1;
      end
      S_HOLDOFF: if (tick_q >= HOLDOFF_TICKS) begin
        state_d = S_IDLE;
        tick_d  = 8'd0;
      end else if (wdt_ce) begin
        tick_d = tick_q + 8'd1;
      end
      default: begin
        state_d     = S_IDLE;
        reset_out_d = 1'b0;
        tick_d      = 8'd0;
      end
    endcase
  end

  // BOOTOK clears before a same-edge bite increments
  always_comb begin
    retry_base = wr_bootok ? 3'd0 : retry_q;
    retry_d    = retry_base;
    cause_d    = wr_bootok ? 2'd0 : cause_q;
    if (bite_acc) begin
      retry_d = (retry_base >= MAX_RETRIES) ? MAX_RETRIES : retry_base + 3'd1;
      cause_d = bite_strobe;
    end
    rec_set = (bite_acc && (retry_d == MAX_RETRIES)) || recovery_req;
    rec_d   = rec_q;
    if (wr_clear) rec_d = 1'b0;
    if (rec_set)  rec_d = 1'b1;
    irq_d = rec_d & ~rec_q;
  end

`ifdef WDT_SEQ_BITE_COUNT_EN
  logic [7:0] bcnt_q, bcnt_d;
  always_comb begin
    bcnt_d = bcnt_q;
    if (bite_acc && (bcnt_q != 8'hff)) bcnt_d = bcnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) bcnt_q <= 8'd0;
    else     bcnt_q <= bcnt_d;
  end
  assign reg3_val = bcnt_q;
`else
  assign reg3_val = 8'h00;
`endif

  always_comb begin
    csr_do = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd0:    csr_do = {rec_q, state_q, cause_q, retry_q};
        2'd3:    csr_do = reg3_val;
        default: csr_do = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= PRESCALE;
      tick_q      <= 8'd0;
      retry_q     <= 3'd0;
      cause_q     <= 2'd0;
      reset_out_q <= 1'b0;
      rec_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      retry_q     <= retry_d;
      cause_q     <= cause_d;
      reset_out_q <= reset_out_d;
      rec_q       <= rec_d;
      irq_q       <= irq_d;
    end
  end

  assign reset_out    = reset_out_q;
  assign recovery_out = rec_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Randomized bench for wdt_reset_sequencer against a timeline-based reference model.
module tb_wdt_reset_sequencer;
  localparam int PER = 4, AT = 2, HT = 2, MAXR = 3, BASE = 8;
`ifdef WDT_SEQ_BITE_COUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       wdt_ce;
  logic [1:0] bite_strobe;
  logic       recovery_req;
  logic       reset_out, recovery_out, irq;

  wdt_reset_sequencer #(.BASE_ADDR(5'h8), .PRESCALE(16'd3), .ASSERT_TICKS(8'd2),
    .HOLDOFF_TICKS(8'd2), .MAX_RETRIES(3'd3), .BOOTOK_VALUE(8'ha5)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_do(csr_do),
    .wdt_ce(wdt_ce), .bite_strobe(bite_strobe), .recovery_req(recovery_req),
    .reset_out(reset_out), .recovery_out(recovery_out), .irq(irq));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: cycle index since reset, and each sequence as an absolute window of cycles
  int cyc, in_seq, aend, idle_at, m_retry, m_cause, m_rec, m_irq, m_bcnt;

  function automatic int kth_ce(input int from, input int k);
    int found = 0;
    for (int c = from; c < from + 64 * PER; c++) begin
      if (c % PER == PER - 1) begin
        found++;
        if (found == k) return c;
      end
    end
    return -1;
  endfunction

  function automatic int m_state();
    if (in_seq != 0 && cyc <= aend) return 1;
    if (in_seq != 0 && cyc < idle_at) return 2;
    return 0;
  endfunction

  function automatic int exp_do();
    int o = (int'(csr_a) - BASE + 32) % 32;
    if (o == 0) return (m_rec << 7) | (m_state() << 5) | (m_cause << 3) | m_retry;
    if (o == 3) return BC_EN ? m_bcnt : 0;
    return 0;
  endfunction

  task automatic model_reset();
    cyc = 0; in_seq = 0; aend = 0; idle_at = 0;
    m_retry = 0; m_cause = 0; m_rec = 0; m_irq = 0; m_bcnt = 0;
  endtask

  task automatic model_edge();
    int st, o, prev, set;
    bit bootok, clr;
    if (rst) begin
      model_reset();
      return;
    end
    st = m_state();
    o = (int'(csr_a) - BASE + 32) % 32;
    bootok = csr_we && o == 1 && csr_di == 8'ha5;
    clr = csr_we && o == 2 && csr_di[0];
    set = 0;
    if (bootok) begin m_retry = 0; m_cause = 0; end
    if (st == 0 && bite_strobe != 2'b00) begin
      m_retry = (m_retry + 1 > MAXR) ? MAXR : m_retry + 1;
      m_cause = bite_strobe;
      if (m_bcnt < 255) m_bcnt++;
      if (m_retry == MAXR) set = 1;
      // reset_out high from cyc+1 until the cycle after the AT-th tick, then HT ticks of blanking
      in_seq = 1;
      aend = kth_ce(cyc + 1, AT) + 1;
      idle_at = kth_ce(aend + 1, HT) + 2;
    end
    if (recovery_req) set = 1;
    prev = m_rec;
    if (clr) m_rec = 0;
    if (set != 0) m_rec = 1;
    m_irq = (m_rec != 0 && prev == 0) ? 1 : 0;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    chk("wdt_ce", wdt_ce, (cyc % PER == PER - 1) ? 1 : 0);
    chk("reset_out", reset_out, (m_state() == 1) ? 1 : 0);
    chk("recovery_out", recovery_out, m_rec);
    chk("irq", irq, m_irq);
    chk("csr_do", csr_do, exp_do());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; csr_we = 1'b0; csr_a = 5'd8; csr_di = 8'h00; bite_strobe = 2'b00; recovery_req = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    step();
    chk("status_after_rst", csr_do, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bite_strobe = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      recovery_req = ($urandom_range(0, 149) == 0);
      csr_we = ($urandom_range(0, 5) == 0);
      csr_a = ($urandom_range(0, 3) != 0) ? 5'(BASE + $urandom_range(0, 3)) : 5'($urandom);
      csr_di = ($urandom_range(0, 1) != 0) ? 8'ha5 : 8'($urandom);
      step();
    end

    // Directed: rst in the middle of an ASSERT window
    idle_inputs();
    repeat (30) step();
    bite_strobe = 2'b01; step();
    bite_strobe = 2'b00; step();
    chk("mid_assert_reset_out", reset_out, 1);
    rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_reset_out", reset_out, 0);
    chk("rst_state_idle", csr_do, 8'h00);
    @(posedge clk); model_edge(); #1;

    // Sustained bites: enough accepted sequences to saturate the optional counter
    bite_strobe = 2'b10;
    csr_a = 5'(BASE + 3);
    repeat (6500) step();
    @(negedge clk);
    chk("bitecnt_sat", csr_do, BC_EN ? 8'hff : 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
